data_router_ctrl: RTL

DATA_ROUTER_CTRL -- requirements
Module: data_router_ctrl

---
 rtl/dr_pkg.sv | 22 ++
 rtl/drc_cmd_reg.sv | 46 ++++
 rtl/data_router_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dr_pkg.sv
// dr_pkg: definitions shared by the data router and its controller.
//   COLW       - width of the router column field
//   RR/BR/RP/NE- rpsel command encodings (NE is reserved, never issued)
//   drc_state_t- controller FSM states
package dr_pkg;

    localparam int unsigned COLW = 28;

    localparam logic [1:0] RR = 2'b00;
    localparam logic [1:0] BR = 2'b01;
    localparam logic [1:0] RP = 2'b10;
    localparam logic [1:0] NE = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        SWEEP    = 3'd2,
        WAIT_BLK = 3'd3,
        DONE     = 3'd4
    } drc_state_t;

endpackage

// File: rtl/drc_cmd_reg.sv
// drc_cmd_reg: registered command hold stage for the data router controller.
//   clk, rst_n          - clock, synchronous active-low reset
//   d_valid/d_rpsel/... - command to present after the next clock edge
//   cmd_ready           - router accepts the presented command this cycle
//   cmd_valid/rpsel/... - registered command outputs to the router
//   xfer                - a command transfers at the coming edge
// The register only reloads when empty or when its content is being
// accepted, so a stalled command keeps every field stable.
module drc_cmd_reg
    import dr_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            d_valid,
    input  logic [1:0]      d_rpsel,
    input  logic [1:0]      d_bank,
    input  logic [1:0]      d_row,
    input  logic [COLW-1:0] d_col,
    input  logic            cmd_ready,
    output logic            cmd_valid,
    output logic [1:0]      rpsel,
    output logic [1:0]      bank,
    output logic [1:0]      row,
    output logic [COLW-1:0] col,
    output logic            xfer
);

    assign xfer = cmd_valid & cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            rpsel     <= RR;
            bank      <= '0;
            row       <= '0;
            col       <= '0;
        end else if (!cmd_valid || cmd_ready) begin
            cmd_valid <= d_valid;
            rpsel     <= d_rpsel;
            bank      <= d_bank;
            row       <= d_row;
            col       <= d_col;
        end
    end

endmodule

// File: rtl/data_router_ctrl.sv
// data_router_ctrl: sequences buffer-fill and window-sweep commands for the
// data router, one job of blk_num blocks per start pulse.
//   clk, rst_n          - clock, synchronous active-low reset
//   start               - begin a job (sampled in IDLE only)
//   blk_num[7:0]        - blocks per job, 0 treated as 1
//   blkend              - router block-complete pulse
//   cmd_ready           - router accepts the presented command
//   cmd_valid, rpsel, bank, row, col[27:0] - router command
//   busy                - high outside IDLE
//   done                - one-cycle end-of-job pulse
// Build option: define DATA_ROUTER_CTRL_BR_FILL_EN to fill every bank with BR
// commands (bank inner, row outer) instead of BUFH RR commands.
module data_router_ctrl
    import dr_pkg::*;
#(
    parameter int unsigned POY    = 3,
    parameter int unsigned BUFW   = 32,
    parameter int unsigned BUFH   = 3,
    parameter int unsigned KSIZE  = 3,
    parameter int unsigned STRIDE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [7:0]      blk_num,
    input  logic            blkend,
    input  logic            cmd_ready,
    output logic            cmd_valid,
    output logic [1:0]      rpsel,
    output logic [1:0]      bank,
    output logic [1:0]      row,
    output logic [COLW-1:0] col,
    output logic            busy,
    output logic            done
);

    if (POY < 1 || POY > 4 || BUFH < 1 || BUFH > 4 || KSIZE < 1 || KSIZE > BUFH ||
        KSIZE > BUFW || (STRIDE != 1 && STRIDE != 2)) begin : g_param_chk
        $error("data_router_ctrl: illegal parameter combination");
    end

    localparam logic [1:0]      ROW_LAST  = 2'(BUFH - 1);
    localparam logic [1:0]      KROW_LAST = 2'(KSIZE - 1);
    localparam logic [COLW-1:0] COL_LAST  = COLW'(((BUFW - KSIZE) / STRIDE) * STRIDE);
    localparam logic [COLW-1:0] COL_STEP  = COLW'(STRIDE);
`ifdef DATA_ROUTER_CTRL_BR_FILL_EN
    localparam logic [1:0]      BANK_LAST = 2'(POY - 1);
`endif

    drc_state_t      state, st_n;
    logic [1:0]      row_q, row_n, bank_q, bank_n;
    logic [COLW-1:0] col_q, col_n;
    logic [7:0]      blk_cnt, blk_cnt_n, blk_lim, blk_lim_n;
    logic            blk_flag, flag_n;
    logic            xfer;

    logic            d_valid;
    logic [1:0]      d_rpsel, d_bank, d_row;
    logic [COLW-1:0] d_col;

    // Counters index the command currently on the outputs; they move only on
    // transfer, and the command register is loaded from the next-state view
    // so the following command appears the cycle after the transfer edge.
    always_comb begin
        st_n      = state;
        row_n     = row_q;
        bank_n    = bank_q;
        col_n     = col_q;
        blk_cnt_n = blk_cnt;
        blk_lim_n = blk_lim;
        flag_n    = blk_flag;
        case (state)
            IDLE: begin
                if (start) begin
                    st_n      = FILL;
                    row_n     = '0;
                    bank_n    = '0;
                    col_n     = '0;
                    blk_cnt_n = '0;
                    blk_lim_n = (blk_num == 8'd0) ? 8'd1 : blk_num;
                    flag_n    = 1'b0;
                end
            end
            FILL: begin
                if (blkend) flag_n = 1'b1;
                if (xfer) begin
`ifdef DATA_ROUTER_CTRL_BR_FILL_EN
                    if (bank_q == BANK_LAST) begin
                        bank_n = '0;
                        if (row_q == ROW_LAST) begin
                            row_n = '0;
                            st_n  = SWEEP;
                        end else begin
                            row_n = row_q + 2'd1;
                        end
                    end else begin
                        bank_n = bank_q + 2'd1;
                    end
`else
                    if (row_q == ROW_LAST) begin
                        row_n = '0;
                        st_n  = SWEEP;
                    end else begin
                        row_n = row_q + 2'd1;
                    end
`endif
                end
            end
            SWEEP: begin
                if (blkend) flag_n = 1'b1;
                if (xfer) begin
                    if (row_q == KROW_LAST) begin
                        row_n = '0;
                        if (col_q == COL_LAST) begin
                            col_n = '0;
                            st_n  = WAIT_BLK;
                        end else begin
                            col_n = col_q + COL_STEP;
                        end
                    end else begin
                        row_n = row_q + 2'd1;
                    end
                end
            end
            WAIT_BLK: begin
                if (blkend || blk_flag) begin
                    flag_n    = 1'b0;
                    blk_cnt_n = blk_cnt + 8'd1;
                    row_n     = '0;
                    bank_n    = '0;
                    col_n     = '0;
                    st_n      = (blk_cnt_n == blk_lim) ? DONE : FILL;
                end
            end
            DONE:    st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    always_comb begin
        d_valid = 1'b0;
        d_rpsel = RR;
        d_bank  = '0;
        d_row   = '0;
        d_col   = '0;
        case (st_n)
            FILL: begin
                d_valid = 1'b1;
`ifdef DATA_ROUTER_CTRL_BR_FILL_EN
                d_rpsel = BR;
`else
                d_rpsel = RR;
`endif
                d_bank  = bank_n;
                d_row   = row_n;
            end
            SWEEP: begin
                d_valid = 1'b1;
                d_rpsel = RP;
                d_row   = row_n;
                d_col   = col_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            row_q    <= '0;
            bank_q   <= '0;
            col_q    <= '0;
            blk_cnt  <= '0;
            blk_lim  <= '0;
            blk_flag <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= st_n;
            row_q    <= row_n;
            bank_q   <= bank_n;
            col_q    <= col_n;
            blk_cnt  <= blk_cnt_n;
            blk_lim  <= blk_lim_n;
            blk_flag <= flag_n;
            busy     <= (st_n != IDLE);
            done     <= (st_n == DONE);
        end
    end

    drc_cmd_reg u_cmd_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_valid   (d_valid),
        .d_rpsel   (d_rpsel),
        .d_bank    (d_bank),
        .d_row     (d_row),
        .d_col     (d_col),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .rpsel     (rpsel),
        .bank      (bank),
        .row       (row),
        .col       (col),
        .xfer      (xfer)
    );

endmodule
